// File: rtl/freq_meter_mc_if.sv
// Signal bundle for freq_meter_mc: test clock inputs, control, and measurement results.
interface freq_meter_mc_if #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 32
);
  logic [CH_NUM-1:0]       clk_test;
  logic                    start;
  logic                    mode;
  logic                    busy;
  logic                    freq_vld;
  logic [CH_NUM*CNT_W-1:0] freq;
  logic [CH_NUM-1:0]       ovf;

  modport master (output clk_test, start, mode, input busy, freq_vld, freq, ovf);
  modport slave  (input clk_test, start, mode, output busy, freq_vld, freq, ovf);
endinterface

// File: rtl/freq_meter_mc.sv
// Multi-channel gate-time frequency meter. Counts rising edges of CH_NUM asynchronous
// test clocks over a CLK_FREQ/GATE_DIV cycle window and reports Hz per channel.
module freq_meter_mc #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int GATE_DIV = 1,
  parameter int CH_NUM   = 4,
  parameter int CNT_W    = 32
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  freq_meter_mc_if.slave mtr
);

  localparam int unsigned GATE_CYC = CLK_FREQ / GATE_DIV;
  localparam int          GC_W     = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int          PW       = CNT_W + 32;

  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

  state_t                        state_q, state_d;
  logic [GC_W-1:0]               gate_q, gate_d;
  logic [CH_NUM-1:0]             s1_q, s2_q, s3_q;
  logic [CH_NUM-1:0]             edge_det;
  logic [CH_NUM-1:0][CNT_W-1:0]  cnt_q;
  logic [CH_NUM-1:0]             ovfp_q;
  logic [CH_NUM-1:0][CNT_W-1:0]  res_d;
  logic [CH_NUM-1:0]             mulovf_d;
  logic [PW-1:0]                 prod;
  logic [CH_NUM-1:0][CNT_W-1:0]  freq_q;
  logic [CH_NUM-1:0]             ovf_q;
  logic                          vld_q;

  assign edge_det = s2_q & ~s3_q;

  // Three-flop synchroniser chain per test clock
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= mtr.clk_test;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Measurement state and gate-cycle counter registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      gate_q  <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
    end
  end

  // Next-state logic: open a window on start (or always in continuous mode), close after GATE_CYC cycles
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    unique case (state_q)
      IDLE: begin
        gate_d = '0;
        if (mtr.mode || mtr.start) state_d = GATE;
      end
      GATE: begin
        if (gate_q == GC_W'(GATE_CYC - 1)) state_d = LATCH;
        else                               gate_d  = gate_q + 1'b1;
      end
      LATCH: begin
        gate_d  = '0;
        state_d = mtr.mode ? GATE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-channel saturating edge counters; ovf_pend records an edge lost at full scale
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      ovfp_q <= '0;
    end else if (state_q == LATCH) begin
      cnt_q  <= '0;
      ovfp_q <= '0;
    end else if (state_q == GATE) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (edge_det[i]) begin
          if (cnt_q[i] == '1) ovfp_q[i] <= 1'b1;
          else                cnt_q[i]  <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Scale edge counts to Hz, saturating to CNT_W bits
  always_comb begin
    res_d    = '0;
    mulovf_d = '0;
    prod     = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      prod        = PW'(cnt_q[i]) * PW'(GATE_DIV);
      mulovf_d[i] = |prod[PW-1:CNT_W];
      res_d[i]    = mulovf_d[i] ? '1 : prod[CNT_W-1:0];
    end
  end

  // Result registers updated in LATCH; valid strobe follows in the next cycle
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      freq_q <= '0;
      ovf_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= (state_q == LATCH);
      if (state_q == LATCH) begin
        freq_q <= res_d;
        ovf_q  <= ovfp_q | mulovf_d;
      end
    end
  end

  assign mtr.busy     = (state_q != IDLE);
  assign mtr.freq_vld = vld_q;
  assign mtr.freq     = freq_q;
  assign mtr.ovf      = ovf_q;

endmodule

// File: tb/tb_freq_meter_mc.sv
// Randomised self-checking bench for freq_meter_mc: two instances (16-bit and 8-bit
// counters) share stimulus and are compared each cycle against an edge-list reference model.
module tb_freq_meter_mc;
  localparam int G   = 100;
  localparam int DIV = 10;
  localparam int NCH = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [NCH-1:0] tb_clk_test = '0;
  logic tb_start = 1'b0;
  logic tb_mode  = 1'b0;

  int per [NCH];
  int off [NCH];
  int tick = 0;

  int n_chk = 0;
  int n_err = 0;

  freq_meter_mc_if #(.CH_NUM(NCH), .CNT_W(16)) f16 ();
  freq_meter_mc_if #(.CH_NUM(NCH), .CNT_W(8))  f8 ();

  assign f16.clk_test = tb_clk_test;
  assign f16.start    = tb_start;
  assign f16.mode     = tb_mode;
  assign f8.clk_test  = tb_clk_test;
  assign f8.start     = tb_start;
  assign f8.mode      = tb_mode;

  freq_meter_mc #(.CLK_FREQ(1000), .GATE_DIV(10), .CH_NUM(NCH), .CNT_W(16)) u_dut16 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mtr(f16));
  freq_meter_mc #(.CLK_FREQ(1000), .GATE_DIV(10), .CH_NUM(NCH), .CNT_W(8)) u_dut8 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mtr(f8));

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Test clock generator: square wave of period per[i] (0 = held low), phase off[i]
  always @(negedge sys_clk) begin
    tick++;
    for (int i = 0; i < NCH; i++) begin
      if (per[i] == 0) tb_clk_test[i] = 1'b0;
      else             tb_clk_test[i] = (((tick + off[i]) % per[i]) < (per[i] / 2));
    end
  end

  // Reference model: list of rising-edge sample times per channel, windows tracked by time
  int  cyc = 0;
  int  rises [NCH][$];
  logic [NCH-1:0] prev_in = '0;
  bit  m_act = 0;
  int  m_e0 = 0;
  bit  e_vld = 0;
  int  e16 [NCH];
  int  e8 [NCH];
  logic [NCH-1:0] eo16 = '0;
  logic [NCH-1:0] eo8 = '0;
  int  n_vld16 = 0;

  always @(posedge sys_clk) begin
    int n, c16, c8, p16, p8;
    cyc++;
    e_vld = 0;
    if (sys_rst) begin
      m_act   = 0;
      prev_in = '0;
      eo16    = '0;
      eo8     = '0;
      for (int i = 0; i < NCH; i++) begin
        rises[i].delete();
        e16[i] = 0;
        e8[i]  = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++)
        if (tb_clk_test[i] && !prev_in[i]) rises[i].push_back(cyc);
      prev_in = tb_clk_test;
      if (m_act && cyc == m_e0 + G + 1) begin
        for (int i = 0; i < NCH; i++) begin
          n = 0;
          foreach (rises[i][k])
            if (rises[i][k] >= m_e0 - 1 && rises[i][k] <= m_e0 + G - 2) n++;
          c16 = (n > 65535) ? 65535 : n;
          c8  = (n > 255) ? 255 : n;
          p16 = c16 * DIV;
          p8  = c8 * DIV;
          e16[i]  = (p16 > 65535) ? 65535 : p16;
          e8[i]   = (p8 > 255) ? 255 : p8;
          eo16[i] = (n > 65535) || (p16 > 65535);
          eo8[i]  = (n > 255) || (p8 > 255);
        end
        e_vld = 1;
        if (tb_mode) m_e0 = cyc;
        else         m_act = 0;
      end else if (!m_act && (tb_mode || tb_start)) begin
        m_act = 1;
        m_e0  = cyc;
      end
      for (int i = 0; i < NCH; i++)
        while (rises[i].size() > 0 && rises[i][0] < cyc - 300) void'(rises[i].pop_front());
    end
    #1;
    if (f16.freq_vld) n_vld16++;
    check_eq("vld16", f16.freq_vld, e_vld);
    check_eq("vld8", f8.freq_vld, e_vld);
    check_eq("busy16", f16.busy, m_act);
    check_eq("busy8", f8.busy, m_act);
    check_eq("ovf16", f16.ovf, eo16);
    check_eq("ovf8", f8.ovf, eo8);
    for (int i = 0; i < NCH; i++) begin
      check_eq($sformatf("freq16_ch%0d", i), f16.freq[i*16 +: 16], e16[i]);
      check_eq($sformatf("freq8_ch%0d", i), f8.freq[i*8 +: 8], e8[i]);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_start();
    @(negedge sys_clk) tb_start = 1'b1;
    @(negedge sys_clk) tb_start = 1'b0;
  endtask

  // Counts rising edges until freq_vld is seen; timeout counts as a failure
  task automatic wait_vld(input int max, output int lat);
    lat = 0;
    forever begin
      @(posedge sys_clk);
      #2;
      lat++;
      if (f16.freq_vld) break;
      if (lat >= max) begin
        check_eq("vld_timeout", lat, 0);
        break;
      end
    end
  endtask

  task automatic rand_phases();
    for (int i = 0; i < NCH; i++) off[i] = $urandom_range(0, 99);
  endtask

  initial begin
    int lat, c0;
    for (int i = 0; i < NCH; i++) begin
      per[i] = 0;
      off[i] = 0;
    end
    wait_cyc(3);
    check_eq("rst_busy", f16.busy, 0);
    check_eq("rst_freq", f16.freq, 0);
    check_eq("rst_ovf", f16.ovf, 0);
    @(negedge sys_clk) sys_rst = 1'b0;
    wait_cyc(5);

    // Single-shot with fixed periods, latency and absolute values
    per[0] = 10; per[1] = 4; per[2] = 0; per[3] = 25;
    rand_phases();
    wait_cyc(30);
    @(negedge sys_clk) tb_start = 1'b1;
    @(posedge sys_clk);
    #2 lat = 1;
    @(negedge sys_clk) tb_start = 1'b0;
    begin
      int l2;
      wait_vld(300, l2);
      lat += l2;
    end
    check_eq("latency", lat, G + 2);
    check_eq("t1_ch0", f16.freq[15:0], 100);
    check_eq("t1_ch1", f16.freq[31:16], 250);
    check_eq("t1_ch2", f16.freq[47:32], 0);
    check_eq("t1_ch3", f16.freq[63:48], 40);
    check_eq("t1_busy_after", f16.busy, 0);
    wait_cyc(20);

    // Randomised single-shot windows
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NCH; i++)
        per[i] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, 30);
      rand_phases();
      wait_cyc($urandom_range(1, 20));
      pulse_start();
      wait_vld(300, lat);
      wait_cyc($urandom_range(1, 10));
    end

    // Continuous mode: regular spacing and steady reading
    per[0] = 10;
    rand_phases();
    @(negedge sys_clk) tb_mode = 1'b1;
    wait_vld(300, lat);
    for (int k = 0; k < 3; k++) begin
      wait_vld(300, lat);
      check_eq("cont_spacing", lat, G + 1);
      check_eq("cont_ch0", f16.freq[15:0], 100);
      check_eq("cont_busy", f16.busy, 1);
    end

    // Mode drop mid-window: current window completes, then idle
    wait_cyc(40);
    @(negedge sys_clk) tb_mode = 1'b0;
    c0 = n_vld16;
    wait_cyc(350);
    check_eq("mode_drop_vlds", n_vld16 - c0, 1);
    check_eq("mode_drop_idle", f16.busy, 0);

    // Saturation on the 8-bit instance, then cleared by an idle window
    per[0] = 2;
    rand_phases();
    wait_cyc(5);
    pulse_start();
    wait_vld(300, lat);
    check_eq("sat8_ch0", f8.freq[7:0], 255);
    check_eq("sat8_ovf0", f8.ovf[0], 1);
    check_eq("sat16_ch0", f16.freq[15:0], 500);
    per[0] = 0;
    wait_cyc(5);
    pulse_start();
    wait_vld(300, lat);
    check_eq("clr8_ch0", f8.freq[7:0], 0);
    check_eq("clr8_ovf0", f8.ovf[0], 0);

    // start during an open window is ignored
    per[0] = $urandom_range(2, 30);
    rand_phases();
    c0 = n_vld16;
    pulse_start();
    wait_cyc(50);
    pulse_start();
    wait_cyc(200);
    check_eq("start_ignored_vlds", n_vld16 - c0, 1);

    // Reset mid-window aborts with no result
    pulse_start();
    wait_cyc(60);
    c0 = n_vld16;
    @(negedge sys_clk) sys_rst = 1'b1;
    #1;
    check_eq("midrst_busy", f16.busy, 0);
    check_eq("midrst_vld", f16.freq_vld, 0);
    check_eq("midrst_freq", f16.freq, 0);
    check_eq("midrst_ovf", f16.ovf, 0);
    check_eq("midrst_freq8", f8.freq, 0);
    wait_cyc(3);
    @(negedge sys_clk) sys_rst = 1'b0;
    wait_cyc(150);
    check_eq("midrst_novld", n_vld16 - c0, 0);
    per[0] = 10; per[1] = 4; per[2] = 0; per[3] = 25;
    rand_phases();
    wait_cyc(5);
    pulse_start();
    wait_vld(300, lat);
    check_eq("post_rst_ch1", f16.freq[31:16], 250);
    wait_cyc(10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
